bar_frame_scheduler: RTL and testbench

//  Double-buffered bar-height store for the audio visualizer.
//  - Spectrum producer writes bins into a back bank via valid/ready.
//  - Banks swap only at VGA vertical-sync falling edge, so no frame ever shows a partial spectrum.
//  - Pixel side maps DrawX/DrawY to bar-hit flags consumed by the color mapper.

---
 rtl/bar_pkg.sv | 14 +
 rtl/bar_peak_tracker.sv | 37 +++
 rtl/bar_frame_scheduler.sv | 138 +++++++++++++
 tb/tb_bar_frame_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bar_pkg.sv
// Shared types and constants for the bar-height frame scheduler.
package bar_pkg;

  typedef enum logic [1:0] {IDLE, FILL, READY} wr_state_t;

  localparam int H_VIS = 480;
  localparam int V_VIS = 640;

  // A bin magnitude is a height in pixels; anything taller than the screen fills the column.
  function automatic logic [9:0] sat_height(input logic [9:0] mag);
    return (mag > 10'(H_VIS)) ? 10'(H_VIS) : mag;
  endfunction

endpackage

// File: rtl/bar_peak_tracker.sv
// Per-bar falling peak markers, refreshed from the new front bank on every swap.
// Only built when PEAK_HOLD_EN is defined.
`ifdef PEAK_HOLD_EN
module bar_peak_tracker
  #(parameter int NUM_BARS = 16,
    parameter int MAG_W    = 9,
    parameter int DECAY    = 2,
    localparam int IDX_W   = $clog2(NUM_BARS))
  (input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      swap,
   input  logic [NUM_BARS*MAG_W-1:0] new_heights,
   input  logic [IDX_W-1:0]          rd_idx,
   output logic [MAG_W-1:0]          rd_peak);

  logic [MAG_W-1:0] peak [NUM_BARS];

  function automatic logic [MAG_W-1:0] next_peak(input logic [MAG_W-1:0] h,
                                                 input logic [MAG_W-1:0] p);
    logic [MAG_W-1:0] d;
    d = (p > MAG_W'(DECAY)) ? p - MAG_W'(DECAY) : '0;
    return (h > d) ? h : d;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BARS; i++) peak[i] <= '0;
    end else if (swap) begin
      for (int i = 0; i < NUM_BARS; i++)
        peak[i] <= next_peak(new_heights[i*MAG_W +: MAG_W], peak[i]);
    end
  end

  assign rd_peak = peak[rd_idx];

endmodule
`endif

// File: rtl/bar_frame_scheduler.sv
// Double-buffered bar-height store: producer fills the back bank, banks swap on vsync falling edge.
// Define PEAK_HOLD_EN to add decaying per-bar peak markers (peak_on); otherwise peak_on is 0.
module bar_frame_scheduler
  import bar_pkg::*;
  #(parameter int NUM_BARS = 16,
    parameter int MAG_W    = 9,
    parameter int BAR_W    = 40,
    parameter int DECAY    = 2,
    localparam int IDX_W   = $clog2(NUM_BARS))
  (input  logic             Clk,
   input  logic             Reset,
   input  logic             bin_valid,
   output logic             bin_ready,
   input  logic [IDX_W-1:0] bin_idx,
   input  logic [MAG_W-1:0] bin_mag,
   input  logic             bin_last,
   input  logic             vs,
   input  logic [9:0]       DrawX,
   input  logic [9:0]       DrawY,
   output logic             bar_on,
   output logic             peak_on,
   output logic [7:0]       swap_count,
   output logic             overrun);

  localparam logic [9:0] BAR_W10 = 10'(BAR_W);
  localparam logic [9:0] SPAN    = 10'(NUM_BARS * BAR_W);

  wr_state_t        state;
  logic             bank_sel;
  logic             vs_q;
  logic [MAG_W-1:0] bank [2][NUM_BARS];

  logic             accept;
  logic             frame_edge;
  logic             swap_pulse;
  logic             idx_ok;
  logic [MAG_W-1:0] wr_mag;

  assign accept     = bin_valid && bin_ready;
  assign frame_edge = vs_q && !vs;
  assign swap_pulse = (state == READY) && frame_edge;
  assign wr_mag     = MAG_W'(sat_height(10'(bin_mag)));

  // Out-of-range indices are only possible when NUM_BARS is not a power of two.
  if ((1 << IDX_W) == NUM_BARS) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = bin_idx < IDX_W'(NUM_BARS);
  end

  // bin_ready is registered from the next state so it is already low in the READY cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      bin_ready  <= 1'b0;
      bank_sel   <= 1'b0;
      swap_count <= '0;
      overrun    <= 1'b0;
      vs_q       <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_BARS; i++) bank[b][i] <= '0;
    end else begin
      vs_q <= vs;
      case (state)
        IDLE, FILL: begin
          bin_ready <= !(accept && bin_last);
          if (accept) begin
            if (idx_ok) bank[~bank_sel][bin_idx] <= wr_mag;
            state <= bin_last ? READY : FILL;
          end
          // A spectrum that completes on the edge cycle is not late; it just swaps next frame.
          if (frame_edge && state == FILL && !(accept && bin_last)) overrun <= 1'b1;
        end
        READY: begin
          if (swap_pulse) begin
            bank_sel   <= ~bank_sel;
            swap_count <= swap_count + 8'd1;
            state      <= IDLE;
            bin_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bin_ready <= 1'b1;
        end
      endcase
    end
  end

  logic [IDX_W-1:0] col;
  logic [9:0]       row_up;
  logic [MAG_W-1:0] front_h;
  logic             in_col;
  logic             bar_on_d;
  logic             peak_on_d;

  assign col     = IDX_W'(DrawX / BAR_W10);
  assign row_up  = 10'(H_VIS - 1) - DrawY;
  assign front_h = bank[bank_sel][col];
  assign in_col  = (DrawX < SPAN) && (DrawX < 10'(V_VIS)) &&
                   ((DrawX % BAR_W10) != (BAR_W10 - 10'd1)) && (DrawY < 10'(H_VIS));
  assign bar_on_d = in_col && (row_up < 10'(front_h));

`ifdef PEAK_HOLD_EN
  logic [NUM_BARS*MAG_W-1:0] back_flat;
  logic [MAG_W-1:0]          peak_h;

  // The bank about to become front is the one the tracker folds into the peaks.
  always_comb begin
    back_flat = '0;
    for (int i = 0; i < NUM_BARS; i++) back_flat[i*MAG_W +: MAG_W] = bank[~bank_sel][i];
  end

  bar_peak_tracker #(.NUM_BARS(NUM_BARS), .MAG_W(MAG_W), .DECAY(DECAY)) u_peak (
    .Clk         (Clk),
    .Reset       (Reset),
    .swap        (swap_pulse),
    .new_heights (back_flat),
    .rd_idx      (col),
    .rd_peak     (peak_h));

  assign peak_on_d = in_col && (peak_h != '0) &&
                     ((row_up == 10'(peak_h)) || (row_up == 10'(peak_h) + 10'd1));
`else
  assign peak_on_d = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bar_on  <= 1'b0;
      peak_on <= 1'b0;
    end else begin
      bar_on  <= bar_on_d;
      peak_on <= peak_on_d;
    end
  end

endmodule

// File: tb/tb_bar_frame_scheduler.sv
// Scoreboard bench for bar_frame_scheduler: stimulus queues expectations, a monitor checks them.
module tb_bar_frame_scheduler;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       bin_valid;
  logic       bin_ready;
  logic [3:0] bin_idx;
  logic [8:0] bin_mag;
  logic       bin_last;
  logic       vs;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       bar_on;
  logic       peak_on;
  logic [7:0] swap_count;
  logic       overrun;

  localparam int S_BAR = 0, S_PEAK = 1, S_SWAP = 2, S_OVR = 3, S_RDY = 4;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bar_frame_scheduler dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .bin_idx    (bin_idx),
    .bin_mag    (bin_mag),
    .bin_last   (bin_last),
    .vs         (vs),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .bar_on     (bar_on),
    .peak_on    (peak_on),
    .swap_count (swap_count),
    .overrun    (overrun));

  always #5 Clk = ~Clk;

  function automatic int actual(input int sel);
    case (sel)
      S_BAR:   return {31'd0, bar_on};
      S_PEAK:  return {31'd0, peak_on};
      S_SWAP:  return {24'd0, swap_count};
      S_OVR:   return {31'd0, overrun};
      default: return {31'd0, bin_ready};
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int sel, input int exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] idx, input logic [8:0] mag,
                               input logic last, input logic vs_val);
    bin_valid = v;
    bin_idx   = idx;
    bin_mag   = mag;
    bin_last  = last;
    vs        = vs_val;
    step();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 9'd0, 1'b0, 1'b1);
  endtask

  task automatic frameEdge();
    applyStimulus(1'b0, 4'd0, 9'd0, 1'b0, 1'b0);
  endtask

  task automatic setPixel(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
  endtask

  task automatic sendBin(input int idx, input int mag, input logic last);
    int k;
    k = 0;
    while (!bin_ready && k < 20) begin
      idle();
      k++;
    end
    if (!bin_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: actual bin_ready=0 required 1 within 20 cycles");
    end
    applyStimulus(1'b1, 4'(idx), 9'(mag), last, 1'b1);
    bin_valid = 1'b0;
  endtask

  task automatic sendZeros(input int first);
    for (int i = first; i < 16; i++) sendBin(i, 0, i == 15);
  endtask

  // Monitor: compare every queued expectation against the DUT at the falling edge.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge Clk);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = actual(e.sel);
        checks++;
        if (act != e.exp) begin
          errors++;
          $display("[TB] FAIL %s: actual %0d required %0d", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1; bin_valid = 1'b0; bin_idx = '0; bin_mag = '0; bin_last = 1'b0;
    vs = 1'b1; DrawX = '0; DrawY = '0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset_bin_ready", S_RDY, 0);
    checkOutput("reset_swap_count", S_SWAP, 0);
    checkOutput("reset_overrun", S_OVR, 0);
    checkOutput("reset_bar_on", S_BAR, 0);
    checkOutput("reset_peak_on", S_PEAK, 0);
    Reset = 1'b0;
    step();
    checkOutput("idle_bin_ready", S_RDY, 1);

    // Full spectrum, heights 10*i, then swap.
    for (int i = 0; i < 16; i++) sendBin(i, 10 * i, i == 15);
    checkOutput("t1_ready_low", S_RDY, 0);
    checkOutput("t1_no_swap_before_edge", S_SWAP, 0);
    frameEdge();
    checkOutput("t1_swap_count", S_SWAP, 1);
    checkOutput("t1_ready_after_swap", S_RDY, 1);
    idle();
    setPixel(45, 470);  checkOutput("t1_bar1_top", S_BAR, 1);
    setPixel(45, 469);  checkOutput("t1_bar1_above", S_BAR, 0);
    setPixel(0, 479);   checkOutput("t1_bar0_zero", S_BAR, 0);
    setPixel(600, 330); checkOutput("t1_bar15_top", S_BAR, 1);
    setPixel(600, 329); checkOutput("t1_bar15_above", S_BAR, 0);
    setPixel(639, 479); checkOutput("t1_bar15_gap", S_BAR, 0);

    // Incomplete spectrum at the edge: overrun, no swap.
    for (int i = 0; i < 8; i++) sendBin(i, 200, 1'b0);
    frameEdge();
    checkOutput("t2_overrun", S_OVR, 1);
    checkOutput("t2_no_swap", S_SWAP, 1);
    checkOutput("t2_ready_stays", S_RDY, 1);
    idle();
    setPixel(45, 470);  checkOutput("t2_front_kept_top", S_BAR, 1);
    setPixel(45, 469);  checkOutput("t2_front_kept_above", S_BAR, 0);
    for (int i = 8; i < 16; i++) sendBin(i, 300, i == 15);

    // READY holds off the producer until the edge.
    applyStimulus(1'b1, 4'd3, 9'd77, 1'b0, 1'b1);
    checkOutput("t3_ready_low_a", S_RDY, 0);
    applyStimulus(1'b1, 4'd3, 9'd77, 1'b0, 1'b1);
    checkOutput("t3_ready_low_b", S_RDY, 0);
    checkOutput("t3_no_swap", S_SWAP, 1);
    applyStimulus(1'b1, 4'd3, 9'd77, 1'b0, 1'b0);
    checkOutput("t3_swap_count", S_SWAP, 2);
    checkOutput("t3_ready_next", S_RDY, 1);
    idle();
    setPixel(45, 280);  checkOutput("t3_bar1_top", S_BAR, 1);
    setPixel(45, 279);  checkOutput("t3_bar1_above", S_BAR, 0);
    frameEdge();
    checkOutput("idle_edge_no_swap", S_SWAP, 2);
    checkOutput("idle_edge_ready", S_RDY, 1);
    idle();

    // Last bin lands on the edge cycle: swap deferred to the next edge.
    for (int i = 0; i < 15; i++) sendBin(i, 50, 1'b0);
    applyStimulus(1'b1, 4'd15, 9'd50, 1'b1, 1'b0);
    checkOutput("t4_no_swap_on_edge", S_SWAP, 2);
    checkOutput("t4_ready_low", S_RDY, 0);
    idle();
    frameEdge();
    checkOutput("t4_swap_next_edge", S_SWAP, 3);
    idle();
    setPixel(45, 430);  checkOutput("t4_bar1_top", S_BAR, 1);
    setPixel(45, 429);  checkOutput("t4_bar1_above", S_BAR, 0);

    // Saturation and column boundaries.
    sendBin(0, 511, 1'b0);
    sendZeros(1);
    frameEdge();
    checkOutput("t5_swap_count", S_SWAP, 4);
    idle();
    setPixel(0, 0);     checkOutput("t5_sat_full", S_BAR, 1);
    setPixel(39, 0);    checkOutput("t5_gap", S_BAR, 0);
    setPixel(38, 0);    checkOutput("t5_last_body_col", S_BAR, 1);
    setPixel(640, 479); checkOutput("t5_right_of_bars", S_BAR, 0);
    setPixel(0, 480);   checkOutput("t5_below_screen", S_BAR, 0);
    setPixel(45, 479);  checkOutput("t5_height0", S_BAR, 0);

    // Asynchronous reset in the middle of a spectrum.
    for (int i = 0; i < 4; i++) sendBin(i, 123, 1'b0);
    Reset = 1'b1;
    #1;
    checkOutput("mid_reset_swap_count", S_SWAP, 0);
    checkOutput("mid_reset_overrun", S_OVR, 0);
    checkOutput("mid_reset_ready", S_RDY, 0);
    step();
    step();
    Reset = 1'b0;
    step();
    checkOutput("post_reset_ready", S_RDY, 1);
    setPixel(0, 0);     checkOutput("post_reset_bank_clear", S_BAR, 0);

`ifdef PEAK_HOLD_EN
    sendBin(0, 100, 1'b0);
    sendZeros(1);
    frameEdge();
    idle();
    setPixel(0, 379);   checkOutput("pk1_row100", S_PEAK, 1);
    checkOutput("pk1_bar_not_at_100", S_BAR, 0);
    setPixel(0, 378);   checkOutput("pk1_row101", S_PEAK, 1);
    setPixel(0, 380);   checkOutput("pk1_row99", S_PEAK, 0);
    sendZeros(0);
    frameEdge();
    idle();
    setPixel(0, 381);   checkOutput("pk2_row98", S_PEAK, 1);
    setPixel(0, 380);   checkOutput("pk2_row99", S_PEAK, 1);
    setPixel(0, 382);   checkOutput("pk2_row97", S_PEAK, 0);
    setPixel(0, 379);   checkOutput("pk2_row100", S_PEAK, 0);
    sendZeros(0);
    frameEdge();
    idle();
    setPixel(0, 383);   checkOutput("pk3_row96", S_PEAK, 1);
    setPixel(0, 382);   checkOutput("pk3_row97", S_PEAK, 1);
    setPixel(0, 381);   checkOutput("pk3_row98", S_PEAK, 0);
    setPixel(45, 479);  checkOutput("pk3_zero_peak", S_PEAK, 0);
`else
    setPixel(0, 479);   checkOutput("no_peak_feature", S_PEAK, 0);
`endif

    idle();
    idle();
    @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
